// File: rtl/control_fsm_if.sv
// Signal bundle between control_fsm and the RV32I multicycle datapath:
// instruction fields, ALU flags, memory handshake and datapath controls.
interface control_fsm_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic       instr_done;
  logic       illegal_instr;

  modport master (
    input  opcode, funct3, zero, lt, ltu, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           instr_done, illegal_instr
  );

  modport slave (
    output opcode, funct3, zero, lt, ltu, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           instr_done, illegal_instr
  );
endinterface

// File: rtl/control_fsm.sv
// Multicycle main control FSM for the RV32I core. Define CONTROL_ILLEGAL_TRAP_EN
// to trap unknown opcodes in HALT; by default they retire as a NOP.
module control_fsm (
  input logic           clk,
  input logic           rst,
  control_fsm_if.master bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_AUIPC    = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11,
    S_ALUWB    = 4'd12,
    S_BRANCH   = 4'd13,
    S_HALT     = 4'd14
  } state_e;

  state_e     state_q, state_d;
  logic       mem_req_s, mem_write_s, adr_src_s, ir_write_s;
  logic       pc_update_s, branch_s, reg_write_s, instr_done_s, taken_s;
  logic [1:0] alu_src_a_s, alu_src_b_s, alu_op_s, result_src_s;

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic slt, input logic sltu);
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = ~z;
      3'b100:  t = slt;
      3'b101:  t = ~slt;
      3'b110:  t = sltu;
      3'b111:  t = ~sltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d      = state_q;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    reg_write_s  = 1'b0;
    instr_done_s = 1'b0;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    result_src_s = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        if (bus.mem_ready) begin
          ir_write_s  = 1'b1;
          pc_update_s = 1'b1;
          state_d     = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // PC-relative target precomputed into ALUOut for branches and JAL
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_REG:            state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d      = S_FETCH;
            instr_done_s = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        if (bus.opcode == OP_LOAD) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        mem_req_s = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        if (bus.mem_ready) begin
          instr_done_s = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b11;
        state_d     = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a_s = 2'b11;
        alu_src_b_s = 2'b01;
        state_d     = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        state_d     = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        state_d     = S_JAL;
      end
      S_JAL: begin
        // PC takes the target in ALUOut while the ALU forms the link value
        pc_update_s = 1'b1;
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s  = 2'b10;
        alu_op_s     = 2'b01;
        branch_s     = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Immediate format select, decoded straight from the opcode
  always_comb begin
    bus.imm_src = 3'b000;
    case (bus.opcode)
      OP_STORE:         bus.imm_src = 3'b001;
      OP_BRANCH:        bus.imm_src = 3'b010;
      OP_JAL:           bus.imm_src = 3'b011;
      OP_LUI, OP_AUIPC: bus.imm_src = 3'b100;
      default:          bus.imm_src = 3'b000;
    endcase
  end

  assign taken_s = branch_taken(bus.funct3, bus.zero, bus.lt, bus.ltu);

  // Strobes are held low for as long as reset is asserted
  assign bus.mem_req    = mem_req_s & ~rst;
  assign bus.mem_write  = mem_write_s & ~rst;
  assign bus.ir_write   = ir_write_s & ~rst;
  assign bus.pc_write   = (pc_update_s | (branch_s & taken_s)) & ~rst;
  assign bus.reg_write  = reg_write_s & ~rst;
  assign bus.instr_done = instr_done_s & ~rst;
  assign bus.adr_src    = adr_src_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.result_src = result_src_s;
`ifdef CONTROL_ILLEGAL_TRAP_EN
  assign bus.illegal_instr = (state_q == S_HALT) & ~rst;
`else
  assign bus.illegal_instr = 1'b0;
`endif
endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: a per-instruction cycle plan built from the
// instruction-class rules is compared against the DUT every cycle.
module tb_control_fsm;
  logic clk = 1'b0;
  logic rst;

  control_fsm_if bus ();

  control_fsm dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef CONTROL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
  localparam int UNK_CYC = 0;
`else
  localparam bit TRAP = 1'b0;
  localparam int UNK_CYC = 2;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic [1:0] rs;
    logic       done;
    logic       ill;
  } outs_t;

  typedef struct packed {
    logic  rdy;
    outs_t o;
  } step_t;

  step_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic outs_t dut_outs();
    outs_t o;
    o.mem_req   = bus.mem_req;
    o.mem_write = bus.mem_write;
    o.adr_src   = bus.adr_src;
    o.ir_write  = bus.ir_write;
    o.pc_write  = bus.pc_write;
    o.reg_write = bus.reg_write;
    o.a         = bus.alu_src_a;
    o.b         = bus.alu_src_b;
    o.op        = bus.alu_op;
    o.rs        = bus.result_src;
    o.done      = bus.instr_done;
    o.ill       = bus.illegal_instr;
    return o;
  endfunction

  function automatic step_t st(input logic rdy, input logic mreq, input logic mw,
                               input logic adr, input logic irw, input logic pcw,
                               input logic rw, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] op, input logic [1:0] rs,
                               input logic done, input logic ill);
    step_t s;
    s.rdy = rdy;
    s.o = '{mem_req: mreq, mem_write: mw, adr_src: adr, ir_write: irw, pc_write: pcw,
            reg_write: rw, a: a, b: b, op: op, rs: rs, done: done, ill: ill};
    return s;
  endfunction

  // Plan one instruction from its class, drive it cycle by cycle and compare.
  task automatic run(input string name, input logic [6:0] opc, input logic [2:0] f3,
                     input logic z, input logic slt, input logic sltu,
                     input int fw, input int mw, input int exp_cyc, input int exp_pcw,
                     input int abort_at);
    step_t e;
    step_t aluwb;
    step_t memadr;
    int n, ndone, done_at, npcw;
    bit unk, tk, imm_ok;
    logic [2:0] imm_exp;
    n = 0; ndone = 0; done_at = 0; npcw = 0;
    aluwb  = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    memadr = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    unk = !(opc inside {OP_LOAD, OP_STORE, OP_REG, OP_IMM, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC});
    case (f3)
      3'b000:  tk = z;
      3'b001:  tk = !z;
      3'b100:  tk = slt;
      3'b101:  tk = !slt;
      3'b110:  tk = sltu;
      3'b111:  tk = !sltu;
      default: tk = 1'b0;
    endcase
    imm_ok = 1'b1;
    case (opc)
      OP_LOAD, OP_IMM, OP_JALR: imm_exp = 3'b000;
      OP_STORE:                 imm_exp = 3'b001;
      OP_BRANCH:                imm_exp = 3'b010;
      OP_JAL:                   imm_exp = 3'b011;
      OP_LUI, OP_AUIPC:         imm_exp = 3'b100;
      default: begin imm_exp = 3'b000; imm_ok = 1'b0; end
    endcase

    q.delete();
    for (int i = 0; i < fw; i++)
      q.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0));
    q.push_back(st(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0));
    q.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, unk & !TRAP, 1'b0));
    if (opc == OP_REG) begin
      q.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
      q.push_back(aluwb);
    end else if (opc == OP_IMM) begin
      q.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b11, 2'b00, 1'b0, 1'b0));
      q.push_back(aluwb);
    end else if (opc == OP_LUI || opc == OP_AUIPC) begin
      q.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (opc == OP_LUI) ? 2'b11 : 2'b01,
                     2'b01, 2'b00, 2'b00, 1'b0, 1'b0));
      q.push_back(aluwb);
    end else if (opc == OP_JAL || opc == OP_JALR) begin
      if (opc == OP_JALR) q.push_back(memadr);
      q.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0));
      q.push_back(aluwb);
    end else if (opc == OP_LOAD || opc == OP_STORE) begin
      q.push_back(memadr);
      for (int i = 0; i < mw; i++)
        q.push_back(st(1'b0, 1'b1, opc == OP_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
      q.push_back(st(1'b1, 1'b1, opc == OP_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00,
                     opc == OP_STORE, 1'b0));
      if (opc == OP_LOAD)
        q.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0));
    end else if (opc == OP_BRANCH) begin
      q.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tk, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0));
    end else if (TRAP) begin
      for (int i = 0; i < 3; i++)
        q.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
    end else begin
      imm_ok = 1'b0;
    end

    bus.opcode = opc; bus.funct3 = f3; bus.zero = z; bus.lt = slt; bus.ltu = sltu;
    while (q.size() > 0 && (abort_at == 0 || n < abort_at)) begin
      e = q.pop_front();
      bus.mem_ready = e.rdy;
      #1;
      chk($sformatf("%s.cyc%0d", name, n), 32'(dut_outs()), 32'(e.o));
      if (imm_ok) chk($sformatf("%s.imm%0d", name, n), 32'(bus.imm_src), 32'(imm_exp));
      if (bus.instr_done === 1'b1) begin
        ndone++;
        if (ndone == 1) done_at = n + 1;
      end
      if (bus.pc_write === 1'b1) npcw++;
      n++;
      @(posedge clk);
      #1;
    end
    if (exp_cyc == 0) begin
      chk({name, ".ndone"}, 32'(ndone), 32'd0);
    end else begin
      chk({name, ".ndone"}, 32'(ndone), 32'd1);
      chk({name, ".cycles"}, 32'(done_at), 32'(exp_cyc));
    end
    chk({name, ".pcw"}, 32'(npcw), 32'(exp_pcw));
  endtask

  task automatic chk_reset_strobes(input string name);
    chk(name, 32'({bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write,
                   bus.mem_write, bus.instr_done, bus.illegal_instr}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_strobes("reset.strobes");
    rst = 1'b0;

    //  name       opcode     f3      z     lt    ltu   fw mw cyc pcw abort
    run("r",       OP_REG,    3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 4,  1,  0);
    run("load_w2", OP_LOAD,   3'b010, 1'b0, 1'b0, 1'b0, 0, 2, 7,  1,  0);
    run("bne_t",   OP_BRANCH, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 3,  2,  0);
    run("bne_n",   OP_BRANCH, 3'b001, 1'b1, 1'b0, 1'b0, 0, 0, 3,  1,  0);
    run("bltu_t",  OP_BRANCH, 3'b110, 1'b0, 1'b0, 1'b1, 0, 0, 3,  2,  0);
    run("beq_n",   OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b1, 0, 0, 3,  1,  0);
    run("bge_t",   OP_BRANCH, 3'b101, 1'b0, 1'b0, 1'b1, 0, 0, 3,  2,  0);
    run("br010_n", OP_BRANCH, 3'b010, 1'b1, 1'b1, 1'b1, 0, 0, 3,  1,  0);
    run("jalr",    OP_JALR,   3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 5,  2,  0);
    run("jal_fw2", OP_JAL,    3'b000, 1'b0, 1'b0, 1'b0, 2, 0, 6,  2,  0);
    run("opimm",   OP_IMM,    3'b111, 1'b0, 1'b0, 1'b0, 0, 0, 4,  1,  0);
    run("lui",     OP_LUI,    3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 4,  1,  0);
    run("auipc",   OP_AUIPC,  3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 4,  1,  0);
    run("store_w1",OP_STORE,  3'b010, 1'b0, 1'b0, 1'b0, 0, 1, 5,  1,  0);
    run("unknown", 7'b0000000,3'b000, 1'b0, 1'b0, 1'b0, 0, 0, UNK_CYC, 1, 0);

    rst = 1'b1;
    #1;
    chk_reset_strobes("unk_rst.strobes");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run("r_after_unk", OP_REG, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0);

    // Abort a store while it waits for memory
    run("st_abort", OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 0, 5, 0, 1, 4);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk_reset_strobes("abort_rst1.strobes");
    @(posedge clk);
    #1;
    chk_reset_strobes("abort_rst2.strobes");
    rst = 1'b0;
    run("r_after_abort", OP_REG, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle main control state machine for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It also generates the 2-bit `alu_op` consumed by the ALU control decoder: 00 = ADD, 01 = SUB, 10 = R-type (funct3/funct7), 11 = I-type (funct3). It sits between the instruction register and the datapath. Memory accesses use a req/ready handshake, so wait states stretch the sequence.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  7  instruction register [6:0]
- `funct3`  in  3  instruction register [14:12]; used for branch condition
- `zero`, `lt`, `ltu`  in  1 each  ALU flags of current-cycle SUB (equal, signed less, unsigned less)
- `mem_ready`  in  1  memory completes the request this cycle
- `mem_req`  out  1  memory request; address and `mem_write` held stable until `mem_ready`
- `mem_write`  out  1  request is a store
- `adr_src`  out  1  0 = PC, 1 = ALUOut
- `ir_write`  out  1  load instruction register and oldPC
- `pc_write`  out  1  load PC from result bus
- `reg_write`  out  1  write rd
- `alu_src_a`  out  2  00 = PC, 01 = oldPC, 10 = rs1 reg, 11 = zero
- `alu_src_b`  out  2  00 = rs2 reg, 01 = imm, 10 = constant 4
- `alu_op`  out  2  see summary
- `result_src`  out  2  00 = ALUOut, 01 = data reg, 10 = ALU result
- `imm_src`  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U; combinational from `opcode`
- `instr_done`  out  1  one-cycle pulse on the retiring cycle
- `illegal_instr`  out  1  see Configuration

## Operation
- Moore outputs decode the 4-bit registered state. `pc_write` is `pc_update | (branch & taken)`.
- Unlisted outputs are 0. `alu_op` defaults to 00.
- States and transitions:
  - FETCH: adr_src=0, mem_req, A=PC, B=4, ADD, result_src=10. On `mem_ready`: ir_write, pc_update, go to DECODE. Otherwise hold.
  - DECODE: A=oldPC, B=imm, ADD (branch/JAL target into ALUOut). Dispatch by opcode:
    - 0000011/0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - anything else → ILLEGAL handling
  - MEMADR: A=rs1, B=imm, ADD. Load → MEMREAD; store → MEMWRITE.
  - MEMREAD: adr_src=1, mem_req. On ready → MEMWB.
  - MEMWB: result_src=01, reg_write, instr_done → FETCH.
  - MEMWRITE: adr_src=1, mem_req, mem_write. On ready: instr_done, go to FETCH.
  - EXECR: A=rs1, B=rs2, alu_op=10 → ALUWB.
  - EXECI: A=rs1, B=imm, alu_op=11 → ALUWB.
  - LUI: A=zero, B=imm, ADD → ALUWB.
  - AUIPC: A=oldPC, B=imm, ADD → ALUWB.
  - JALR: A=rs1, B=imm, ADD → JAL. The datapath clears target bit 0.
  - JAL: result_src=00, pc_update, A=oldPC, B=4, ADD → ALUWB.
  - ALUWB: result_src=00, reg_write, instr_done → FETCH.
  - BRANCH: A=rs1, B=rs2, alu_op=01, result_src=00, instr_done → FETCH.
- Branch taken by funct3:
  - 000 `zero`, 001 `!zero`
  - 100 `lt`, 101 `!lt`
  - 110 `ltu`, 111 `!ltu`
  - 010/011 never taken
- `mem_ready` is ignored while `mem_req`=0.

## Timing
- Reset: state = FETCH.
  - While `rst`=1, the strobes `mem_req`, `ir_write`, `pc_write`, `reg_write`, `mem_write` and `instr_done` are forced to 0.
  - `illegal_instr` is cleared.
  - Fetch begins the first cycle after `rst` falls.
- `rst` mid-instruction aborts the sequence the next edge; no partial writeback follows.
- Cycles per instruction with zero wait states:
  - branch 3
  - R, I, LUI, AUIPC, JAL, store 4
  - load, JALR 5
  - Each cycle `mem_ready` stays low adds one cycle.
- `mem_ready` asserted in the first request cycle completes the access in that cycle.
- `instr_done` is high exactly one cycle per retired instruction.

## Configuration
- `CONTROL_ILLEGAL_TRAP_EN` defined: an unknown opcode in DECODE enters HALT.
  - HALT has all strobes 0 and `illegal_instr`=1.
  - HALT is left only by `rst`.
- Not defined: an unknown opcode goes DECODE → FETCH as a NOP.
  - `instr_done` pulses in DECODE.
  - `illegal_instr` is tied 0.

## Test plan
- After reset, present `opcode`=0110011 with `mem_ready` tied 1. Expect FETCH→DECODE→EXECR (alu_op=10)→ALUWB, `reg_write` in cycle 4, `instr_done` once.
- Load with `mem_ready` low for 2 cycles in MEMREAD. Expect `mem_req`/`adr_src`=1 held 3 cycles, `reg_write` with result_src=01, 7 cycles total.
- BNE (funct3=001) with `zero`=0. Expect `pc_write`=1 in BRANCH. Repeat with `zero`=1: `pc_write`=0. BLTU with `ltu`=1: taken.
- JALR. Expect A=rs1/B=imm in JALR, then `pc_write` in JAL, then `reg_write` in ALUWB, 5 cycles.
- Opcode 0000000. With the macro: HALT, `illegal_instr`=1 until `rst`. Without it: back to FETCH after 2 cycles.
- Assert `rst` in MEMWRITE while waiting. Expect no further `mem_write`, FETCH after the edge, strobes 0 during reset.
